// File: rtl/rca_share_ctrl.sv
// rca_share_ctrl: one ripple-carry adder (rca) shared by NREQ requesters.
// A round-robin arbiter picks a pending request in IDLE. The operands are
// registered and added in ADD. The sum is then returned in RESP on a
// valid/ready channel, tagged with the requester index.
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   req_valid_i/req_ready_o   per-requester handshake (ready one-hot, comb)
//   req_a_i, req_b_i          packed operands, requester k at [k*WIDTH +: WIDTH]
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_sum_o, rsp_id_o       full-width sum and requester index
//   busy_o                    high outside IDLE
//   op_count_o                completed responses, wraps

// Plain ripple-carry adder with the carry-out in the sum MSB.
module rca #(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width:0]   sum
);
  logic [width:0] c;

  assign c[0] = 1'b0;
  for (genvar i = 0; i < width; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign sum[width] = c[width];
endmodule

module rca_share_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NREQ-1:0]             req_valid_i,
  input  logic [NREQ*WIDTH-1:0]       req_a_i,
  input  logic [NREQ*WIDTH-1:0]       req_b_i,
  output logic [NREQ-1:0]             req_ready_o,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [WIDTH:0]              rsp_sum_o,
  output logic [$clog2(NREQ)-1:0]     rsp_id_o,
  output logic                        busy_o,
  output logic [COUNT_W-1:0]          op_count_o
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               rsp_valid_d;
  logic [WIDTH:0]     rsp_sum_d;
  logic [IDW-1:0]     rsp_id_d;
  logic [COUNT_W-1:0] op_count_d;

  logic               found;
  logic [IDW-1:0]     winner;
  logic [IDW:0]       cand;
  logic [WIDTH:0]     sum_c;

  // Round-robin search from the pointer upward, wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req_valid_i[IDW'(cand)]) begin
        found  = 1'b1;
        winner = IDW'(cand);
      end
    end
  end

  // Grant is combinational so a requester sees acceptance in the same cycle.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && !rst_i && found) req_ready_o[winner] = 1'b1;
  end

  assign busy_o = (state_q != IDLE);

  // The adder sees only registered operands.
  rca #(.width(WIDTH)) u_rca (
    .a   (a_q),
    .b   (b_q),
    .sum (sum_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_o;
    rsp_sum_d   = rsp_sum_o;
    rsp_id_d    = rsp_id_o;
    op_count_d  = op_count_o;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = req_a_i[winner*WIDTH +: WIDTH];
          b_d     = req_b_i[winner*WIDTH +: WIDTH];
          id_d    = winner;
          ptr_d   = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
          state_d = ADD;
        end
      end
      ADD: begin
        rsp_sum_d   = sum_c;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_o + COUNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_o <= 1'b0;
      rsp_sum_o   <= '0;
      rsp_id_o    <= '0;
      op_count_o  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_sum_o   <= rsp_sum_d;
      rsp_id_o    <= rsp_id_d;
      op_count_o  <= op_count_d;
    end
  end
endmodule

// File: tb/tb_rca_share_ctrl.sv
// Directed bench for rca_share_ctrl (WIDTH=8, NREQ=4); a second instance
// with COUNT_W=4 shares all inputs to observe counter wrap.
module tb_rca_share_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic        rsp_ready;
  logic [3:0]  req_ready, req_ready4;
  logic        rsp_valid, rsp_valid4;
  logic [8:0]  rsp_sum, rsp_sum4;
  logic [1:0]  rsp_id, rsp_id4;
  logic        busy, busy4;
  logic [15:0] op_count;
  logic [3:0]  op_count4;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  rca_share_ctrl #(.WIDTH(8), .NREQ(4), .COUNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_a_i(req_a),
    .req_b_i(req_b), .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_sum_o(rsp_sum), .rsp_id_o(rsp_id),
    .busy_o(busy), .op_count_o(op_count)
  );

  rca_share_ctrl #(.WIDTH(8), .NREQ(4), .COUNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_a_i(req_a),
    .req_b_i(req_b), .req_ready_o(req_ready4), .rsp_valid_o(rsp_valid4),
    .rsp_ready_i(rsp_ready), .rsp_sum_o(rsp_sum4), .rsp_id_o(rsp_id4),
    .busy_o(busy4), .op_count_o(op_count4)
  );

  typedef struct {
    logic [3:0] valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] ready;
    logic [8:0] sum;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; runs one full accept/add/respond cycle.
  task automatic do_op(input vec_t v, input string tag);
    req_valid = v.valid;
    req_a     = {4{v.a}};
    req_b     = {4{v.b}};
    rsp_ready = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(req_ready), 32'(v.ready));
    @(negedge clk);
    req_valid = '0;
    check({tag, ".add_busy"}, 32'(busy), 32'd1);
    check({tag, ".add_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".sum"}, 32'(rsp_sum), 32'(v.sum));
    check({tag, ".id"}, 32'(rsp_id), 32'(v.id));
    @(negedge clk);
    exp_cnt++;
    check({tag, ".idle_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".count"}, 32'(op_count), 32'(exp_cnt % 65536));
    check({tag, ".count4"}, 32'(op_count4), 32'(exp_cnt % 16));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Starting pointer 0 for the table; expected winners hand-traced.
    vecs[0] = '{4'b1111, 8'd255, 8'd255, 4'b0001, 9'd510, 2'd0};
    vecs[1] = '{4'b1111, 8'd0,   8'd0,   4'b0010, 9'd0,   2'd1};
    vecs[2] = '{4'b0001, 8'd255, 8'd1,   4'b0001, 9'd256, 2'd0};
    vecs[3] = '{4'b1001, 8'd17,  8'd34,  4'b1000, 9'd51,  2'd3};
    vecs[4] = '{4'b0110, 8'd100, 8'd27,  4'b0010, 9'd127, 2'd1};
    vecs[5] = '{4'b0011, 8'd128, 8'd128, 4'b0001, 9'd256, 2'd0};
    vecs[6] = '{4'b1100, 8'd1,   8'd254, 4'b0100, 9'd255, 2'd2};
    vecs[7] = '{4'b0111, 8'd99,  8'd1,   4'b0001, 9'd100, 2'd0};
    vecs[8] = '{4'b1000, 8'd254, 8'd255, 4'b1000, 9'd509, 2'd3};

    // Reset state, with requests pending to show no grant during reset.
    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.sum", 32'(rsp_sum), 32'd0);
    check("rst.id", 32'(rsp_id), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.count", 32'(op_count), 32'd0);
    rst = 1'b0; req_valid = '0;
    @(negedge clk);

    // Single request from requester 2.
    v = '{4'b0100, 8'd200, 8'd100, 4'b0100, 9'd300, 2'd2};
    do_op(v, "single");

    // Reset while in ADD: pointer is 3, requester 1 wins, then reset drops it.
    req_valid = 4'b0010; req_a = {4{8'd5}}; req_b = {4{8'd6}};
    #1 check("rstadd.ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("rstadd.valid", 32'(rsp_valid), 32'd0);
    check("rstadd.busy", 32'(busy), 32'd0);
    check("rstadd.count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("rstadd.after_valid", 32'(rsp_valid), 32'd0);
    check("rstadd.after_busy", 32'(busy), 32'd0);
    // Pointer back at 0: {1,3} valid must pick 1, then 3 alone.
    v = '{4'b1010, 8'd9, 8'd9, 4'b0010, 9'd18, 2'd1};
    do_op(v, "ptr0");
    v = '{4'b1000, 8'd10, 8'd20, 4'b1000, 9'd30, 2'd3};
    do_op(v, "k3");

    // Table of single transactions.
    for (int i = 0; i < 9; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // All four requesting continuously: grants 0,1,2,3,0,1 every 3 cycles.
    for (int k = 0; k < 4; k++) begin
      req_a[k*8 +: 8] = 8'(10 * k + 1);
      req_b[k*8 +: 8] = 8'(k);
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1 check($sformatf("rr%0d.ready", g), 32'(req_ready), 32'(1 << (g % 4)));
      @(negedge clk);
      check($sformatf("rr%0d.add_ready", g), 32'(req_ready), 32'd0);
      @(negedge clk);
      check($sformatf("rr%0d.valid", g), 32'(rsp_valid), 32'd1);
      check($sformatf("rr%0d.id", g), 32'(rsp_id), 32'(g % 4));
      check($sformatf("rr%0d.sum", g), 32'(rsp_sum), 32'(11 * (g % 4) + 1));
      @(negedge clk);
      exp_cnt++;
    end
    req_valid = '0;
    check("wrap.count", 32'(op_count), 32'd17);
    check("wrap.count4", 32'(op_count4), 32'd1);

    // Backpressure: pointer at 2, only requester 0 valid.
    req_valid = 4'b0001; req_a = {4{8'd7}}; req_b = {4{8'd8}}; rsp_ready = 1'b0;
    #1 check("bp.ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d.sum", i), 32'(rsp_sum), 32'd15);
      check($sformatf("bp%0d.id", i), 32'(rsp_id), 32'd0);
      check($sformatf("bp%0d.ready", i), 32'(req_ready), 32'd0);
      check($sformatf("bp%0d.busy", i), 32'(busy), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("bp.ack_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    exp_cnt++;
    check("bp.idle_valid", 32'(rsp_valid), 32'd0);
    check("bp.idle_busy", 32'(busy), 32'd0);
    check("bp.count", 32'(op_count), 32'(exp_cnt));
    check("bp.count4", 32'(op_count4), 32'(exp_cnt % 16));
    check("bp.next_grant", 32'(req_ready), 32'b0010);
    req_valid = '0;
    #1 check("idle.ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("idle.busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
